// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: owns HI/LO, runs an iterative shift-add
// multiplier or restoring divider and stalls the pipeline through busy.
module mdu_unit #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data,
    output logic [1:0]       state_dbg
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
    state_t state, state_nx;

    logic             accept, op_mul, op_div, op_signed, op_mthi, op_mtlo, op_legal;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod, prod_res;
    logic [WIDTH-1:0] quo_res, rem_res;

    // Handshake: a request transfers on a rising edge where in_valid & in_ready
    // are both high, flush is low and opcode is 0; in_ready depends only on state.
    assign accept    = in_valid & in_ready & ~flush & (opcode == 6'h00);
    assign state_dbg = state;
    assign mf_data   = (funct == 6'h10) ? hi : lo;

    always_comb begin
        op_mul    = (funct == 6'h18) || (funct == 6'h19);
        op_div    = (funct == 6'h1A) || (funct == 6'h1B);
        op_signed = (funct == 6'h18) || (funct == 6'h1A);
        op_mthi   = (funct == 6'h11);
        op_mtlo   = (funct == 6'h13);
        op_legal  = op_mul || op_div || op_mthi || op_mtlo ||
                    (funct == 6'h10) || (funct == 6'h12);
        a_neg     = op_signed & rs_val[WIDTH-1];
        b_neg     = op_signed & rt_val[WIDTH-1];
        a_mag     = a_neg ? -rs_val : rs_val;
        b_mag     = b_neg ? -rt_val : rt_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept && (op_mul || op_div)) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (flush)                        state_nx = IDLE;
                else if (cnt == CW'(N - 1))       state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // BPC unrolled iterations per cycle; acc_hi is the running sum or remainder.
    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        sum     = {(WIDTH+1){1'b0}};
        for (int i = 0; i < BPC; i++) begin
            if (is_div) begin
                sum     = {step_hi, step_lo[WIDTH-1]};
                step_lo = {step_lo[WIDTH-2:0], 1'b0};
                if (sum >= {1'b0, opnd}) begin
                    sum        = sum - {1'b0, opnd};
                    step_lo[0] = 1'b1;
                end
                step_hi = sum[WIDTH-1:0];
            end else begin
                sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
                step_lo = {sum[0], step_lo[WIDTH-1:1]};
                step_hi = sum[WIDTH:1];
            end
        end
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_res = neg_q ? -prod : prod;
        quo_res  = div_zero ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
        rem_res  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
        end else begin
            done    <= (state == FIX) & ~flush;
            illegal <= accept & ~op_legal;
            if (accept && op_mthi) hi <= rs_val;
            if (accept && op_mtlo) lo <= rs_val;
            if (accept && (op_mul || op_div)) begin
                is_div   <= op_div;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= op_div & a_neg;
                div_zero <= op_div & (rt_val == '0);
                opnd     <= op_div ? b_mag : a_mag;
                acc_hi   <= '0;
                acc_lo   <= op_div ? a_mag : b_mag;
                cnt      <= '0;
            end else if (state == CALC) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + CW'(1);
            end
            if ((state == FIX) && !flush) begin
                if (is_div) begin
                    hi <= rem_res;
                    lo <= quo_res;
                end else begin
                    {hi, lo} <= prod_res;
                end
            end
        end
    end
endmodule
